fwft_fifo_param: RTL and testbench

Parametrised first-word-fall-through FIFO built around a DEPTH x DATA_W register-file store with synchronous write and asynchronous read. The head entry is always presented on rd_data while the FIFO is non-empty. Wrap-bit pointers, occupancy count, programmable almost-full/almost-empty flags and overflow/underflow error pulses are all included. It sits between a producer and a consumer in the same clock domain and replaces the fixed 8x8 FIFO datapath.

---
 rtl/fwft_fifo_param.sv | 67 ++++++
 tb/tb_fwft_fifo_param.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fwft_fifo_param.sv
// First-word-fall-through FIFO: register-file store with synchronous write and
// combinational head read, wrap-bit pointers, level flags and error pulses.
module fwft_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = (1 << ADDR_W) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Handshake: a write transfers on a rising edge when wr_en=1 and full=0; a
  // read (pop of the word shown on rd_data) transfers when rd_en=1 and empty=0.
  // Requests made against full/empty are dropped and reported one cycle later.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);
  assign rd_data      = mem[rd_ptr[ADDR_W-1:0]];

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_fwft_fifo_param.sv
// Scoreboard bench for fwft_fifo_param at default parameters (8 x 8).
module tb_fwft_fifo_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full, empty, almost_full, almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow, underflow;

  fwft_fifo_param dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  int m_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags(input logic exp_ovf, input logic exp_unf);
    check("count", 32'(count), 32'(m_count));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("almost_full", 32'(almost_full), 32'(m_count >= DEPTH - 1));
    check("almost_empty", 32'(almost_empty), 32'(m_count <= 1));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
    if (m_count > 0) check("head", 32'(rd_data), 32'(exp_q[0]));
  endtask

  // driver: one clock cycle with the given requests, then scoreboard update
  task automatic cycle(input logic we, input logic [DATA_W-1:0] wd, input logic re);
    logic w_ok, r_ok, e_ovf, e_unf;
    wr_en = we; wr_data = wd; rd_en = re;
    w_ok  = we && (m_count < DEPTH);
    r_ok  = re && (m_count > 0);
    e_ovf = we && (m_count == DEPTH);
    e_unf = re && (m_count == 0);
    if (r_ok) begin
      check("pop_data", 32'(rd_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (w_ok) exp_q.push_back(wd);
    m_count = m_count + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
    @(posedge clk); #1;
    check_flags(e_ovf, e_unf);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    while (m_count > 0) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #3;
    check_flags(1'b0, 1'b0);
    #9 rst_n = 1'b1;

    // three writes, head visible right after first
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    drain();

    // fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    idle();
    drain();

    // underflow from empty
    cycle(1'b0, '0, 1'b1);
    idle();

    // simultaneous on full: read wins, write dropped
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    drain();

    // simultaneous on empty: write wins, read dropped
    cycle(1'b1, 8'hC5, 1'b1);
    drain();

    // steady state at count 4 across two pointer wraps
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b1);
    drain();

    // async reset mid-cycle with count 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_count = 0;
    check_flags(1'b0, 1'b0);
    #2 rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
